mul_pipe_param: RTL and testbench



---
 rtl/mul_pkg.sv | 33 +++
 rtl/mul_pipe_stage.sv | 46 ++++
 rtl/mul_pipe_param.sv | 102 ++++++++++
 tb/tb_mul_pipe_param.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types and helpers for the parametrised pipelined multiplier.
// trunc_error gives the value dropped by omitting the low partial-product columns.
package mul_pkg;

   localparam int MAX_W  = 32;
   localparam int MAX_PW = 2 * MAX_W;

   function automatic int prod_width(input int w);
      return 2 * w;
   endfunction

   typedef struct packed {
      logic              valid;
      logic              is_signed;
      logic [MAX_PW-1:0] data;
   } stage_t;

   function automatic logic [MAX_PW-1:0] trunc_error(input logic [MAX_W-1:0] a,
                                                     input logic [MAX_W-1:0] b,
                                                     input int               trunc);
      logic [MAX_PW-1:0] d;
      d = '0;
      for (int i = 0; i < MAX_W; i++) begin
         for (int j = 0; j < MAX_W; j++) begin
            if ((i + j < trunc) && a[i] && b[j]) begin
               d = d + (MAX_PW'(1) << (i + j));
            end
         end
      end
      return d;
   endfunction

endpackage

// File: rtl/mul_pipe_stage.sv
// One enable-gated pipeline register; a bubble entering the stage clears its data.
module mul_pipe_stage
   import mul_pkg::*;
#(
   parameter int PW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          d_valid,
   input  logic          d_sign,
   input  logic [PW-1:0] d_data,
   output logic          q_valid,
   output logic          q_sign,
   output logic [PW-1:0] q_data
);

   stage_t payload_d, payload_q;
   logic   unused_payload;

   always_comb begin
      payload_d = payload_q;
      if (en) begin
         payload_d = '0;
         if (d_valid) begin
            payload_d.valid     = 1'b1;
            payload_d.is_signed = d_sign;
            payload_d.data      = MAX_PW'(d_data);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         payload_q <= '0;
      end else begin
         payload_q <= payload_d;
      end
   end

   assign q_valid        = payload_q.valid;
   assign q_sign         = payload_q.is_signed;
   assign q_data         = payload_q.data[PW-1:0];
   assign unused_payload = ^payload_q;

endmodule

// File: rtl/mul_pipe_param.sv
// Pipelined WIDTHxWIDTH multiplier with per-transaction signed mode, optional low-column
// truncation and a globally stalled valid/ready pipeline of STAGES registers.
module mul_pipe_param
   import mul_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int STAGES = 3,
   parameter int TRUNC  = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 is_signed,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   o
);

   localparam int PW = prod_width(WIDTH);
   // Baugh-Wooley constant: 2^W - 2^(2W-1), which is 2^W + 2^(2W-1) modulo 2^(2W).
   localparam logic [PW-1:0] BW_CORR = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));

   logic          stall;
   logic          adv;
   logic          accept;
   logic [PW-1:0] array_sum;
   logic          vld  [STAGES];
   logic          sgn  [STAGES];
   logic [PW-1:0] data [STAGES];
   logic          unused_sign;

   function automatic logic [PW-1:0] sign_fix(input logic [PW-1:0] x, input logic s);
      return s ? (x + BW_CORR) : x;
   endfunction

   assign stall    = vld[STAGES-1] & ~out_ready;
   assign adv      = ~stall;
   assign in_ready = adv;
   assign accept   = in_valid & adv;

   // Columns below TRUNC are never generated; in signed mode the bits pairing exactly one
   // MSB are inverted, and the matching constant is added on entry to the last stage.
   always_comb begin
      logic pp;
      pp        = 1'b0;
      array_sum = '0;
      for (int i = 0; i < WIDTH; i++) begin
         for (int j = 0; j < WIDTH; j++) begin
            if (i + j >= TRUNC) begin
               pp = a[i] & b[j];
               if (is_signed && ((i == WIDTH - 1) != (j == WIDTH - 1))) begin
                  pp = ~pp;
               end
               array_sum = array_sum + (PW'(pp) << (i + j));
            end
         end
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic          d_valid;
      logic          d_sign;
      logic [PW-1:0] d_src;
      logic [PW-1:0] d_data;

      if (k == 0) begin : g_head
         assign d_valid = accept;
         assign d_sign  = is_signed;
         assign d_src   = array_sum;
      end else begin : g_body
         assign d_valid = vld[k-1];
         assign d_sign  = sgn[k-1];
         assign d_src   = data[k-1];
      end

      if (k == STAGES - 1) begin : g_fix
         assign d_data = sign_fix(d_src, d_sign);
      end else begin : g_pass
         assign d_data = d_src;
      end

      mul_pipe_stage #(.PW(PW)) u_stage (
         .clk     (clk),
         .rst     (rst),
         .en      (adv),
         .d_valid (d_valid),
         .d_sign  (d_sign),
         .d_data  (d_data),
         .q_valid (vld[k]),
         .q_sign  (sgn[k]),
         .q_data  (data[k])
      );
   end

   assign out_valid   = vld[STAGES-1];
   assign o           = data[STAGES-1];
   assign unused_sign = sgn[STAGES-1];

endmodule

// File: tb/tb_mul_pipe_param.sv
// Bench for mul_pipe_param: directed table and corner sequences on an 8x8/3-stage instance,
// plus randomized and exhaustive streams on truncating configurations against a plain-arithmetic model.
module tb_mul_pipe_param;
   import mul_pkg::*;

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      bit          s;
      logic [15:0] exp;
   } vec_t;

   typedef struct {
      logic [63:0] exp;
      int          cyc;
   } pend_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int nvec = 0;
   int nerr = 0;

   logic        m_rst = 1'b1;
   logic        m_iv = 1'b0;
   logic        m_ordy = 1'b1;
   logic        m_s = 1'b0;
   logic [7:0]  m_a = '0;
   logic [7:0]  m_b = '0;
   logic        m_ir, m_ov;
   logic [15:0] m_o;

   mul_pipe_param #(.WIDTH(8), .STAGES(3), .TRUNC(0)) u_main (
      .clk(clk), .rst(m_rst), .in_valid(m_iv), .in_ready(m_ir), .a(m_a), .b(m_b),
      .is_signed(m_s), .out_valid(m_ov), .out_ready(m_ordy), .o(m_o)
   );

   task automatic chk(input string nm, input int id, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", nm, id, act, exp);
      end
   endtask

   // Exact product from sign/zero-extended integers, minus the dropped low columns.
   function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                            input bit s, input int w, input int t);
      longint      ax, bx;
      logic [63:0] m, p;
      m  = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
      ax = longint'({32'd0, a});
      bx = longint'({32'd0, b});
      if (s && a[w-1]) ax = ax - (longint'(1) << w);
      if (s && b[w-1]) bx = bx - (longint'(1) << w);
      p = ax * bx;
      p = p - trunc_error(a, b, t);
      return p & m;
   endfunction

   function automatic int cfg_w(input int g);
      case (g)
         0:       return 8;
         1, 2:    return 4;
         default: return 16;
      endcase
   endfunction

   function automatic int cfg_s(input int g);
      case (g)
         0:       return 3;
         1, 3:    return 1;
         default: return 8;
      endcase
   endfunction

   function automatic int cfg_t(input int g);
      case (g)
         0:       return 4;
         1, 2:    return 3;
         default: return 15;
      endcase
   endfunction

   function automatic int cfg_n(input int g);
      case (g)
         0:       return 10000;
         1, 2:    return 512;
         default: return 2000;
      endcase
   endfunction

   for (genvar g = 0; g < 5; g++) begin : g_cfg
      localparam int W = cfg_w(g);
      localparam int S = cfg_s(g);
      localparam int T = cfg_t(g);
      localparam int N = cfg_n(g);
      localparam logic [63:0] TMASK = (64'd1 << T) - 64'd1;

      logic           g_rst = 1'b1;
      logic           g_iv = 1'b0;
      logic           g_or = 1'b1;
      logic           g_s = 1'b0;
      logic [W-1:0]   g_a = '0;
      logic [W-1:0]   g_b = '0;
      logic           g_ir, g_ov;
      logic [2*W-1:0] g_o;
      pend_t          q[$];
      int             cyc = 0;
      int             idx = 0;

      mul_pipe_param #(.WIDTH(W), .STAGES(S), .TRUNC(T)) u_dut (
         .clk(clk), .rst(g_rst), .in_valid(g_iv), .in_ready(g_ir), .a(g_a), .b(g_b),
         .is_signed(g_s), .out_valid(g_ov), .out_ready(g_or), .o(g_o)
      );

      task automatic step(input bit v, input bit r, input bit lat_on);
         logic [31:0] oa, ob;
         bit          os;
         int          n;
         pend_t       p;
         @(negedge clk);
         cyc++;
         if (W == 4) begin
            n  = idx % 512;
            oa = 32'(n & 15);
            ob = 32'((n >> 4) & 15);
            os = ((n >> 8) & 1) != 0;
         end else begin
            oa = $urandom() & ((32'd1 << W) - 32'd1);
            ob = $urandom() & ((32'd1 << W) - 32'd1);
            os = $urandom_range(0, 1) != 0;
         end
         if (g == 0 && idx == 0) begin
            oa = 32'h0F;
            ob = 32'h0F;
            os = 1'b0;
         end
         g_a  = oa[W-1:0];
         g_b  = ob[W-1:0];
         g_s  = os;
         g_iv = v;
         g_or = r;
         #1;
         if (g_ov && g_or) begin
            if (q.size() == 0) begin
               chk("spurious_out", g, 64'(q.size()), 64'd1);
            end else begin
               p = q.pop_front();
               chk("rand_product", g, 64'(g_o), p.exp);
               chk("low_cols_zero", g, 64'(g_o) & TMASK, 64'd0);
               if (lat_on) chk("rand_latency", g, 64'(cyc - p.cyc), 64'(S));
            end
         end
         if (!g_ov) chk("idle_o_zero", g, 64'(g_o), 64'd0);
         if (g_iv && g_ir) begin
            p.exp = (g == 0 && idx == 0) ? 64'h00B0 : ref_prod(oa, ob, os, W, T);
            p.cyc = cyc;
            q.push_back(p);
            idx++;
         end
      endtask

      task automatic drain(input bit lat_on);
         int k;
         k = 0;
         while (q.size() > 0 && k < 100) begin
            step(1'b0, 1'b1, lat_on);
            k++;
         end
         chk("drain_left", g, 64'(q.size()), 64'd0);
      endtask

      task automatic run();
         int guard;
         repeat (3) @(negedge clk);
         g_rst = 1'b0;
         guard = 0;
         while (idx < N / 2 && guard < N * 4) begin
            step(1'b1, 1'b1, 1'b1);
            guard++;
         end
         drain(1'b1);
         guard = 0;
         while (idx < N && guard < N * 8) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 1'b0);
            guard++;
         end
         drain(1'b0);
         chk("accepted_count", g, 64'(idx), 64'(N));
      endtask
   end

   vec_t tbl [10];

   task automatic single(input logic [7:0] ta, input logic [7:0] tb_, input bit ts,
                         input logic [15:0] exp, input int id);
      int lat;
      @(negedge clk);
      m_a    = ta;
      m_b    = tb_;
      m_s    = ts;
      m_iv   = 1'b1;
      m_ordy = 1'b1;
      #1 chk("single_in_ready", id, 64'(m_ir), 64'd1);
      @(negedge clk);
      m_iv = 1'b0;
      lat  = 1;
      while (!m_ov && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk("single_latency", id, 64'(lat), 64'd3);
      chk("single_product", id, 64'(m_o), 64'(exp));
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int          sent, rcv;
      bit          st, prev_st;
      logic [15:0] prev_o;
      logic [63:0] r;
      logic [7:0]  ra, rb;
      bit          rs;

      tbl[0] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
      tbl[1] = '{8'h80, 8'h80, 1'b1, 16'h4000};
      tbl[2] = '{8'hFF, 8'h01, 1'b1, 16'hFFFF};
      tbl[3] = '{8'h80, 8'h7F, 1'b1, 16'hC080};
      tbl[4] = '{8'h7F, 8'h7F, 1'b1, 16'h3F01};
      tbl[5] = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
      tbl[6] = '{8'h80, 8'hFF, 1'b0, 16'h7F80};
      tbl[7] = '{8'h00, 8'hA5, 1'b1, 16'h0000};
      tbl[8] = '{8'hFF, 8'h80, 1'b1, 16'h0080};
      tbl[9] = '{8'h12, 8'h34, 1'b0, 16'h03A8};

      repeat (3) @(negedge clk);
      m_rst = 1'b0;
      #1;
      chk("reset_out_valid", 0, 64'(m_ov), 64'd0);
      chk("reset_o", 0, 64'(m_o), 64'd0);
      chk("reset_in_ready", 0, 64'(m_ir), 64'd1);

      for (int i = 0; i < 10; i++) single(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].exp, i);

      // Back-to-back signed operands come out on consecutive cycles, in order.
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         m_ordy = 1'b1;
         m_iv   = (c < 3);
         if (c < 3) begin
            m_a = tbl[c+1].a;
            m_b = tbl[c+1].b;
            m_s = tbl[c+1].s;
         end
         #1;
         if (c >= 3 && c < 6) begin
            chk("b2b_valid", c, 64'(m_ov), 64'd1);
            chk("b2b_product", c, 64'(m_o), 64'(tbl[c-2].exp));
         end
         if (c == 6) begin
            chk("b2b_idle_valid", c, 64'(m_ov), 64'd0);
            chk("b2b_idle_o", c, 64'(m_o), 64'd0);
         end
      end

      // Backpressure window on cycles 4..8 of a six-operand stream.
      sent = 0;
      rcv = 0;
      prev_st = 1'b0;
      prev_o = '0;
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         m_ordy = !(c >= 4 && c <= 8);
         m_iv   = (sent < 6);
         if (sent < 6) begin
            m_a = tbl[sent].a;
            m_b = tbl[sent].b;
            m_s = tbl[sent].s;
         end
         #1;
         st = m_ov && !m_ordy;
         if (st) chk("bp_in_ready", c, 64'(m_ir), 64'd0);
         if (st && prev_st) chk("bp_hold", c, 64'(m_o), 64'(prev_o));
         if (m_ov && m_ordy) begin
            if (rcv < 6) chk("bp_order", c, 64'(m_o), 64'(tbl[rcv].exp));
            else chk("bp_extra_output", c, 64'(rcv), 64'd5);
            rcv++;
         end
         if (m_iv && m_ir) sent++;
         prev_st = st;
         prev_o  = m_o;
      end
      chk("bp_count", 0, 64'(rcv), 64'd6);

      // Reset with three products in flight; the operand offered during reset is dropped.
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         m_ordy = 1'b1;
         m_iv   = 1'b1;
         m_a    = tbl[c].a;
         m_b    = tbl[c].b;
         m_s    = tbl[c].s;
         if (c == 3) m_rst = 1'b1;
      end
      @(negedge clk);
      m_rst = 1'b0;
      m_iv  = 1'b0;
      #1;
      chk("rst_out_valid", 0, 64'(m_ov), 64'd0);
      chk("rst_o", 0, 64'(m_o), 64'd0);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         #1 chk("rst_no_output", c, 64'(m_ov), 64'd0);
      end
      single(tbl[3].a, tbl[3].b, tbl[3].s, tbl[3].exp, 100);

      for (int i = 0; i < 100; i++) begin
         ra = 8'($urandom());
         rb = 8'($urandom());
         rs = $urandom_range(0, 1) != 0;
         r  = ref_prod(32'(ra), 32'(rb), rs, 8, 0);
         single(ra, rb, rs, r[15:0], 200 + i);
      end

      g_cfg[0].run();
      g_cfg[1].run();
      g_cfg[2].run();
      g_cfg[3].run();
      g_cfg[4].run();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
